timer8_top: RTL and testbench

//  8-bit up/down timer/counter with an APB slave register interface and one level interrupt.

---
 rtl/timer8_top.sv | 175 +++++++++++++++++
 tb/tb_timer8_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer8_top.sv
// rtl/timer8_top.sv - 8-bit up/down timer/counter with APB register slave
//
// Purpose:
//   8-bit up/down counter prescaled from pclk by 1/2/4/8. It sets overflow and
//   underflow status flags and drives one level interrupt. Its registers sit on
//   an APB slave port with zero wait states.
//
// Register map (paddr):
//   0x00 TDR  RW   load value
//   0x01 TCR  RW   [7]load [5]dir(0 up,1 down) [4]en [1:0]cks
//   0x02 TSR  W1C  [0]OVF [1]UDF
//   0x03 TIE  RW   [0]OVIE [1]UDIE
//   0x04 TCNT RO   counter value (writable when TIMER_TCNT_WR_EN is defined)
//   Other addresses: writes ignored, reads 0x00. Reserved bits read 0.
//
// Configuration macro:
//   TIMER_TCNT_WR_EN - when defined, an APB write to 0x04 loads TCNT directly.
//   This write takes priority over a count in the same cycle.
//
// Ports:
//   pclk      in   1  clock for the APB port and the counter
//   presetn   in   1  asynchronous active-low reset
//   psel      in   1  APB select
//   penable   in   1  APB access phase
//   pwrite    in   1  1 = write, 0 = read
//   paddr     in   8  register address
//   pwdata    in   8  write data
//   prdata    out  8  read data, 0x00 when no read is selected
//   pready    out  1  always 1
//   interrupt out  1  level interrupt, active-high

module timer8_top (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       interrupt
);

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIE  = 8'h03;
  localparam logic [7:0] ADDR_TCNT = 8'h04;

  logic [7:0] tdr_q,  tdr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       load_q, load_d;
  logic       dir_q,  dir_d;
  logic       en_q,   en_d;
  logic [1:0] cks_q,  cks_d;
  logic [1:0] tsr_q,  tsr_d;   // [0] OVF, [1] UDF
  logic [1:0] tie_q,  tie_d;   // [0] OVIE, [1] UDIE
  logic [2:0] div_q,  div_d;

  logic       wr_en;
  logic       rd_en;
  logic       tcnt_wr;
  logic       tick;
  logic       count;
  logic       ovf_set;
  logic       udf_set;
  logic [1:0] w1c;

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & ~pwrite;

`ifdef TIMER_TCNT_WR_EN
  assign tcnt_wr = wr_en & (paddr == ADDR_TCNT);
`else
  assign tcnt_wr = 1'b0;
`endif

  // Tick decode uses the current prescaler value. The first tick after enable
  // therefore lands 1/2/4/8 cycles after en is set.
  always_comb begin
    tick = 1'b0;
    case (cks_q)
      2'b00:   tick = 1'b1;
      2'b01:   tick = div_q[0];
      2'b10:   tick = &div_q[1:0];
      default: tick = &div_q;
    endcase
  end

  assign count   = tick & en_q & ~load_q;
  assign ovf_set = count & ~dir_q & (tcnt_q == 8'hFF);
  assign udf_set = count &  dir_q & (tcnt_q == 8'h00);
  assign w1c     = (wr_en && paddr == ADDR_TSR) ? pwdata[1:0] : 2'b00;

  always_comb begin
    tdr_d  = tdr_q;
    load_d = load_q;
    dir_d  = dir_q;
    en_d   = en_q;
    cks_d  = cks_q;
    tie_d  = tie_q;
    tcnt_d = tcnt_q;

    if (wr_en) begin
      case (paddr)
        ADDR_TDR: tdr_d = pwdata;
        ADDR_TCR: begin
          load_d = pwdata[7];
          dir_d  = pwdata[5];
          en_d   = pwdata[4];
          cks_d  = pwdata[1:0];
        end
        ADDR_TIE: tie_d = pwdata[1:0];
        default: ;
      endcase
    end

    // The prescaler free-runs while enabled. A TCR write does not restart it.
    div_d = en_q ? div_q + 3'd1 : 3'd0;

    if (load_q) begin
      tcnt_d = tdr_q;
    end else if (tcnt_wr) begin
      tcnt_d = pwdata;
    end else if (count) begin
      tcnt_d = dir_q ? tcnt_q - 8'd1 : tcnt_q + 8'd1;
    end

    // A hardware set wins over a W1C of the same bit in the same cycle.
    tsr_d = (tsr_q & ~w1c) | {udf_set, ovf_set};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q  <= 8'h00;
      tcnt_q <= 8'h00;
      load_q <= 1'b0;
      dir_q  <= 1'b0;
      en_q   <= 1'b0;
      cks_q  <= 2'b00;
      tsr_q  <= 2'b00;
      tie_q  <= 2'b00;
      div_q  <= 3'd0;
    end else begin
      tdr_q  <= tdr_d;
      tcnt_q <= tcnt_d;
      load_q <= load_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      cks_q  <= cks_d;
      tsr_q  <= tsr_d;
      tie_q  <= tie_d;
      div_q  <= div_d;
    end
  end

  always_comb begin
    prdata = 8'h00;
    if (rd_en) begin
      case (paddr)
        ADDR_TDR:  prdata = tdr_q;
        ADDR_TCR:  prdata = {load_q, 1'b0, dir_q, en_q, 2'b00, cks_q};
        ADDR_TSR:  prdata = {6'b0, tsr_q};
        ADDR_TIE:  prdata = {6'b0, tie_q};
        ADDR_TCNT: prdata = tcnt_q;
        default:   prdata = 8'h00;
      endcase
    end
  end

  assign pready    = 1'b1;
  assign interrupt = |(tsr_q & tie_q);

endmodule

// File: tb/tb_timer8_top.sv
// tb/tb_timer8_top.sv - scoreboard bench for timer8_top against a behavioural model
module tb_timer8_top;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       interrupt;

  int checks = 0;
  int errors = 0;

  timer8_top dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .interrupt(interrupt)
  );

  always #5 pclk = ~pclk;

`ifdef TIMER_TCNT_WR_EN
  localparam bit TCNT_WRITABLE = 1'b1;
`else
  localparam bit TCNT_WRITABLE = 1'b0;
`endif

  // Reference model state, advanced once per clock from the register rules.
  logic [7:0] m_tdr = 0, m_tcnt = 0;
  logic       m_load = 0, m_dir = 0, m_en = 0;
  logic [1:0] m_cks = 0, m_flags = 0, m_tie = 0;
  int         m_run = 0;   // cycles spent enabled since enable was last set
  bit         m_wr, m_tick;
  int         m_period;
  logic [7:0] m_next;
  logic [1:0] m_set, m_clr;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_tdr = 0; m_tcnt = 0; m_load = 0; m_dir = 0; m_en = 0;
      m_cks = 0; m_flags = 0; m_tie = 0; m_run = 0;
    end else begin
      m_wr     = psel && penable && pwrite;
      m_period = 1 << m_cks;
      m_tick   = m_en && ((m_run % m_period) == m_period - 1);
      m_set    = 2'b00;
      m_next   = m_tcnt;
      if (m_load) m_next = m_tdr;
      else if (m_wr && paddr == 8'h04 && TCNT_WRITABLE) m_next = pwdata;
      else if (m_tick) begin
        if (!m_dir) begin
          if (m_tcnt == 8'hFF) m_set[0] = 1'b1;
          m_next = 8'((int'(m_tcnt) + 1) % 256);
        end else begin
          if (m_tcnt == 8'h00) m_set[1] = 1'b1;
          m_next = 8'((int'(m_tcnt) + 255) % 256);
        end
      end
      m_clr   = (m_wr && paddr == 8'h02) ? pwdata[1:0] : 2'b00;
      m_flags = (m_flags & ~m_clr) | m_set;
      m_run   = m_en ? m_run + 1 : 0;
      m_tcnt  = m_next;
      if (m_wr) begin
        case (paddr)
          8'h00: m_tdr = pwdata;
          8'h01: begin
            m_load = pwdata[7]; m_dir = pwdata[5]; m_en = pwdata[4]; m_cks = pwdata[1:0];
          end
          8'h03: m_tie = pwdata[1:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return {m_load, 1'b0, m_dir, m_en, 2'b00, m_cks};
      8'h02:   return {6'b0, m_flags};
      8'h03:   return {6'b0, m_tie};
      8'h04:   return m_tcnt;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct { logic [7:0] addr; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  // Monitor: compares every completed read against the scoreboard and checks
  // idle prdata, pready and the interrupt level each cycle.
  always @(negedge pclk) begin
    exp_t e;
    logic exp_irq;
    exp_irq = |(m_flags & m_tie);
    checks++;
    if (interrupt !== exp_irq) begin
      errors++;
      $display("FAIL interrupt @%0t: got %b expected %b", $time, interrupt, exp_irq);
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL pready @%0t: got %b expected 1", $time, pready);
    end
    if (psel && penable && !pwrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected @%0t: addr %h got %h with empty scoreboard", $time, paddr, prdata);
      end else begin
        e = exp_q.pop_front();
        if (prdata !== e.data) begin
          errors++;
          $display("FAIL prdata addr %h @%0t: got %h expected %h", e.addr, $time, prdata, e.data);
        end
      end
    end else if (!psel || pwrite) begin
      checks++;
      if (prdata !== 8'h00) begin
        errors++;
        $display("FAIL prdata_idle @%0t: got %h expected 00", $time, prdata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    step(1);
    penable = 1;
    step(1);
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    exp_t e;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    step(1);
    penable = 1;
    e.addr = a;
    e.data = model_read(a);
    exp_q.push_back(e);
    step(1);
    psel = 0; penable = 0;
  endtask

  initial begin
    logic [7:0] a, d;
    int r;
    step(3);
    presetn = 1;
    step(1);

    // Reset values, including an unmapped address.
    foreach (exp_q[i]) ;
    for (int i = 0; i < 5; i++) apb_read(8'(i));
    apb_read(8'h10);

    // Register widths and W1C behaviour of TSR.
    apb_write(8'h00, 8'hFF); apb_write(8'h01, 8'hFF); apb_write(8'h03, 8'hFF);
    apb_read(8'h00); apb_read(8'h01); apb_read(8'h03);
    apb_write(8'h02, 8'hFF); apb_read(8'h02);
    apb_write(8'h01, 8'h00); apb_write(8'h03, 8'h00);

    // Up count across 0xFF -> 0x00 with no interrupt enabled.
    apb_write(8'h00, 8'hFD); apb_write(8'h01, 8'h80); apb_write(8'h01, 8'h10);
    for (int i = 0; i < 4; i++) apb_read(8'h04);
    apb_read(8'h02);

    // Interrupt follows OVF & OVIE, then W1C clears it.
    apb_write(8'h03, 8'h01); step(2);
    apb_write(8'h02, 8'h01); step(2);
    apb_write(8'h03, 8'h00);

    // Down count /8 through underflow.
    apb_write(8'h00, 8'h02); apb_write(8'h01, 8'h80); apb_write(8'h01, 8'h33);
    apb_write(8'h03, 8'h02);
    for (int i = 0; i < 20; i++) apb_read(8'h04);
    apb_read(8'h02);
    apb_write(8'h02, 8'h03);

    // /2 up count, then reset in the middle of counting.
    apb_write(8'h01, 8'h11);
    for (int i = 0; i < 6; i++) apb_read(8'h04);
    presetn = 0; step(2); presetn = 1; step(1);
    apb_read(8'h04); apb_read(8'h02); apb_read(8'h01);

    // Randomized register traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      d = 8'($urandom);
      if (r < 4) begin
        if (a == 8'h01 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
        apb_write(a, d);
      end else if (r < 8) begin
        apb_read(a);
      end else begin
        step($urandom_range(1, 6));
      end
      if (i == 300) begin
        presetn = 0; step(1); presetn = 1; step(1);
      end
    end

    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule
